imem_fetch_ctrl: RTL and testbench
==================================

// Module: imem_fetch_ctrl
// PURPOSE
//  Fetch sequencer/arbiter for the byte-wide, single-port instruction memory.
//  Shares the memory between the core fetch port (4 byte reads -> 32-bit little-endian word)
//  and a boot/program loader port (single-byte writes). Sits between core PC logic and imem array.
// PARAMETERS
//  AW  8  byte-address width of instruction memory (depth 2**AW bytes)
// PORTS
//  clk            in   1   clock, all state updates on rising edge
//  rst            in   1   asynchronous, active-high reset
//  fetch_req      in   1   core requests fetch at fetch_pc
//  fetch_pc       in   32  byte address of instruction
//  fetch_ready    out  1   controller accepts fetch_req this cycle
//  instr_valid    out  1   instr/instr_misalign hold a response
//  instr_ready    in   1   core consumes response
//  instr          out  32  fetched word {b3,b2,b1,b0}
//  instr_misalign out  1   fetch_pc[1:0]!=0; instr=0, no memory access made
//  ld_req         in   1   loader byte-write request
//  ld_addr        in   AW  loader byte address
//  ld_data        in   8   loader write byte
//  ld_ack         out  1   loader write performed this cycle (1-cycle pulse)
//  mem_addr       out  AW  memory byte address
//  mem_we         out  1   memory write enable
//  mem_wdata      out  8   memory write byte
//  mem_rdata      in   8   memory read byte; sync read, valid cycle after mem_addr
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, instr_valid=0, instr=0, instr_misalign=0,
//   ld_ack=0, mem_we=0, mem_addr=0, captured PC=0, byte count=0.
//  States: IDLE, RD (byte counter k=0..3), CAP, RESP.
//  IDLE: ld_req has priority. ld_req=1 -> mem_we=1, mem_addr=ld_addr, mem_wdata=ld_data,
//   ld_ack=1 same cycle, fetch_ready=0. Otherwise fetch_ready=1.
//   fetch_req&fetch_ready: latch fetch_pc; if pc[1:0]!=0 -> RESP with instr=0, misalign=1;
//   else k=0, -> RD.
//  RD: mem_addr=pc[AW-1:0]+k (mod 2**AW; pc bits above AW ignored), mem_we=0.
//   For k>=1 capture mem_rdata into byte k-1. k=3 -> CAP, else k+1.
//  CAP: capture mem_rdata into byte 3 -> RESP.
//  RESP: instr_valid=1; instr/misalign stable until instr_ready=1, then -> IDLE, valid=0.
//  Latency: accept edge -> RD0,RD1,RD2,RD3,CAP -> instr_valid high 6th cycle after accept.
//   Misaligned: instr_valid high cycle after accept.
//  fetch_ready=0 and ld_ack=0 in all states except IDLE; loader requests wait (ld_req held).
//  ld_req ignored outside IDLE (no write, no ack); mem_we only ever asserted in IDLE.
//  Back-to-back fetch: earliest next accept is the cycle after instr_ready handshake.
//  instr updated only on capture; misalign cleared on new aligned accept.
//  Reset mid-fetch: in-flight fetch abandoned, no response; no partial word visible.
// TESTING
//  1. Loader writes B3,81,40,00 to 0..3 (4 acks); fetch pc=0 -> instr=0x004081B3, valid on cycle 6.
//  2. Hold instr_ready=0 for 5 cycles in RESP -> instr/valid stable, fetch_ready=0; release -> IDLE.
//  3. fetch pc=0x2 -> valid next cycle, instr_misalign=1, instr=0, mem_addr never driven to 2.
//  4. ld_req and fetch_req same IDLE cycle -> write+ack first, fetch accepted next cycle.
//  5. AW=8, pc=0x104 with bytes at 4..7 = 23,28,10,00 -> instr=0x00102823.
//  6. Assert rst during RD2 -> outputs at reset values immediately; next fetch completes normally.
//  7. ld_req during RD -> no mem_we, no ack until controller returns to IDLE.

Source files
------------

// File: rtl/imem_fetch_ctrl_if.sv
// Bundle of core-fetch, loader and memory-side signals around the instruction-memory
// fetch controller. The slave modport is the controller; master is its environment.
interface imem_fetch_ctrl_if #(
    parameter int AW = 8
);
    logic          fetch_req;
    logic [31:0]   fetch_pc;
    logic          fetch_ready;
    logic          instr_valid;
    logic          instr_ready;
    logic [31:0]   instr;
    logic          instr_misalign;
    logic          ld_req;
    logic [AW-1:0] ld_addr;
    logic [7:0]    ld_data;
    logic          ld_ack;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;

    modport master (
        output fetch_req, fetch_pc, instr_ready, ld_req, ld_addr, ld_data, mem_rdata,
        input  fetch_ready, instr_valid, instr, instr_misalign, ld_ack,
               mem_addr, mem_we, mem_wdata
    );

    modport slave (
        input  fetch_req, fetch_pc, instr_ready, ld_req, ld_addr, ld_data, mem_rdata,
        output fetch_ready, instr_valid, instr, instr_misalign, ld_ack,
               mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer/arbiter for a byte-wide single-port instruction memory: assembles
// four sync-read bytes into a little-endian word and lets a loader write bytes when idle.
module imem_fetch_ctrl #(
    parameter int AW = 8
) (
    input  logic clk,
    input  logic rst,
    imem_fetch_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_CAP  = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [1:0]    k_r;
    logic [AW-1:0] pc_r;
    logic [23:0]   buf_r;
    logic [31:0]   instr_r;
    logic          misalign_r;
    logic          valid_r;

    logic          accept_s;
    logic          misaligned_s;
    logic          ld_go_s;
    logic          fetch_ready_s;
    logic [AW-1:0] mem_addr_s;
    logic          mem_we_s;
    logic          unused_pc_bits_s;

    assign misaligned_s     = (bus.fetch_pc[1:0] != 2'b00);
    assign unused_pc_bits_s = ^bus.fetch_pc[31:AW];

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and memory/handshake outputs; loader wins over fetch in IDLE.
    always_comb begin
        state_s       = state_r;
        accept_s      = 1'b0;
        ld_go_s       = 1'b0;
        fetch_ready_s = 1'b0;
        mem_addr_s    = '0;
        mem_we_s      = 1'b0;
        if (rst) begin
            state_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (bus.ld_req) begin
                        ld_go_s    = 1'b1;
                        mem_we_s   = 1'b1;
                        mem_addr_s = bus.ld_addr;
                        state_s    = S_IDLE;
                    end else begin
                        fetch_ready_s = 1'b1;
                        if (bus.fetch_req) begin
                            accept_s = 1'b1;
                            state_s  = misaligned_s ? S_RESP : S_RD;
                        end else begin
                            state_s = S_IDLE;
                        end
                    end
                end
                S_RD: begin
                    mem_addr_s = pc_r + AW'(k_r);
                    if (k_r == 2'd3) begin
                        state_s = S_CAP;
                    end else begin
                        state_s = S_RD;
                    end
                end
                S_CAP: begin
                    state_s = S_RESP;
                end
                S_RESP: begin
                    if (bus.instr_ready) begin
                        state_s = S_IDLE;
                    end else begin
                        state_s = S_RESP;
                    end
                end
                default: begin
                    state_s = S_IDLE;
                end
            endcase
        end
    end

    // Datapath: PC latch, byte counter, byte assembly and the response registers.
    // Bytes collect in buf_r so instr only ever changes to a complete word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_r        <= 2'd0;
            pc_r       <= '0;
            buf_r      <= 24'd0;
            instr_r    <= 32'd0;
            misalign_r <= 1'b0;
            valid_r    <= 1'b0;
        end else begin
            valid_r <= (state_s == S_RESP);
            if (accept_s) begin
                pc_r <= bus.fetch_pc[AW-1:0];
                k_r  <= 2'd0;
                if (misaligned_s) begin
                    instr_r    <= 32'd0;
                    misalign_r <= 1'b1;
                end else begin
                    misalign_r <= 1'b0;
                end
            end else if (state_r == S_RD) begin
                k_r <= k_r + 2'd1;
                case (k_r)
                    2'd1:    buf_r[7:0]   <= bus.mem_rdata;
                    2'd2:    buf_r[15:8]  <= bus.mem_rdata;
                    2'd3:    buf_r[23:16] <= bus.mem_rdata;
                    default: buf_r        <= buf_r;
                endcase
            end else if (state_r == S_CAP) begin
                instr_r <= {bus.mem_rdata, buf_r};
            end else begin
                k_r <= k_r;
            end
        end
    end

    assign bus.fetch_ready    = fetch_ready_s;
    assign bus.instr_valid    = valid_r;
    assign bus.instr          = instr_r;
    assign bus.instr_misalign = misalign_r;
    assign bus.ld_ack         = ld_go_s;
    assign bus.mem_addr       = mem_addr_s;
    assign bus.mem_we         = mem_we_s;
    assign bus.mem_wdata      = bus.ld_data;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: directed scenarios followed by random
// loader writes and fetches, compared against a byte-array reference of memory contents.
module tb_imem_fetch_ctrl;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst;
    logic mem_clr;
    int   checks = 0;
    int   failures = 0;

    logic [7:0] ram     [0:255];
    logic [7:0] ref_mem [0:255];

    always #5 clk = ~clk;

    imem_fetch_ctrl_if #(.AW(AW)) bus ();

    imem_fetch_ctrl #(.AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Byte-wide synchronous-read memory behind the controller.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'd0;
            bus.mem_rdata <= 8'd0;
        end else begin
            if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata <= ram[bus.mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Expected word: four consecutive bytes from the reference, wrapping in the 256-byte space.
    function automatic logic [31:0] exp_word(input logic [31:0] pc);
        logic [7:0] b;
        b = pc[7:0];
        return {ref_mem[b + 8'd3], ref_mem[b + 8'd2], ref_mem[b + 8'd1], ref_mem[b]};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, {31'd0, bus.instr_valid}, 32'd0);
        check({tag, "_instr"}, bus.instr, 32'd0);
        check({tag, "_mis"},   {31'd0, bus.instr_misalign}, 32'd0);
        check({tag, "_ack"},   {31'd0, bus.ld_ack}, 32'd0);
        check({tag, "_we"},    {31'd0, bus.mem_we}, 32'd0);
        check({tag, "_addr"},  {24'd0, bus.mem_addr}, 32'd0);
    endtask

    task automatic ld_write(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.ld_req      = 1'b1;
        bus.ld_addr     = a;
        bus.ld_data     = d;
        bus.fetch_req   = 1'b0;
        bus.instr_ready = 1'b0;
        #1;
        check("ld_ack",    {31'd0, bus.ld_ack}, 32'd1);
        check("ld_we",     {31'd0, bus.mem_we}, 32'd1);
        check("ld_addr",   {24'd0, bus.mem_addr}, {24'd0, a});
        check("ld_wdata",  {24'd0, bus.mem_wdata}, {24'd0, d});
        check("ld_fready", {31'd0, bus.fetch_ready}, 32'd0);
        ref_mem[a] = d;
    endtask

    // One complete fetch: accept, wait for the response while checking the busy
    // behaviour, hold the response for 'hold' cycles, then hand it off.
    task automatic fetch(input logic [31:0] pc, input int hold, input logic ld_during);
        int          n;
        int          exp_lat;
        logic        mis;
        logic [31:0] exp_instr;
        logic [7:0]  la;
        logic [7:0]  ld;
        mis       = (pc[1:0] != 2'b00);
        exp_lat   = mis ? 1 : 6;
        la        = 8'($urandom_range(0, 255));
        ld        = 8'($urandom_range(0, 255));
        @(negedge clk);
        bus.ld_req      = 1'b0;
        bus.fetch_req   = 1'b1;
        bus.fetch_pc    = pc;
        bus.instr_ready = 1'b0;
        #1;
        check("fetch_ready", {31'd0, bus.fetch_ready}, 32'd1);
        @(negedge clk);
        bus.fetch_req = 1'b0;
        bus.fetch_pc  = $urandom;
        if (ld_during) begin
            bus.ld_req  = 1'b1;
            bus.ld_addr = la;
            bus.ld_data = ld;
        end
        n = 1;
        #1;
        while (n <= 12 && !bus.instr_valid) begin
            check("busy_fready", {31'd0, bus.fetch_ready}, 32'd0);
            check("busy_ack",    {31'd0, bus.ld_ack}, 32'd0);
            check("busy_we",     {31'd0, bus.mem_we}, 32'd0);
            if (n <= 4) check("rd_addr", {24'd0, bus.mem_addr}, {24'd0, pc[7:0] + 8'(n - 1)});
            @(negedge clk);
            n++;
            #1;
        end
        exp_instr = mis ? 32'd0 : exp_word(pc);
        check("latency",  32'(n), 32'(exp_lat));
        check("instr",    bus.instr, exp_instr);
        check("misalign", {31'd0, bus.instr_misalign}, {31'd0, mis});
        if (mis) check("mis_no_addr", {31'd0, bus.mem_addr == pc[7:0]}, 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            #1;
            check("hold_valid",  {31'd0, bus.instr_valid}, 32'd1);
            check("hold_instr",  bus.instr, exp_instr);
            check("hold_fready", {31'd0, bus.fetch_ready}, 32'd0);
            check("hold_ack",    {31'd0, bus.ld_ack}, 32'd0);
        end
        bus.instr_ready = 1'b1;
        @(negedge clk);
        bus.instr_ready = 1'b0;
        #1;
        check("idle_valid",  {31'd0, bus.instr_valid}, 32'd0);
        check("idle_fready", {31'd0, bus.fetch_ready}, {31'd0, !ld_during});
        if (ld_during) begin
            check("late_ack",  {31'd0, bus.ld_ack}, 32'd1);
            check("late_addr", {24'd0, bus.mem_addr}, {24'd0, la});
            ref_mem[la] = ld;
        end
    endtask

    initial begin
        logic [31:0] pc;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'd0;
        rst             = 1'b1;
        mem_clr         = 1'b1;
        bus.fetch_req   = 1'b0;
        bus.fetch_pc    = 32'd0;
        bus.instr_ready = 1'b0;
        bus.ld_req      = 1'b0;
        bus.ld_addr     = 8'd0;
        bus.ld_data     = 8'd0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst     = 1'b0;
        mem_clr = 1'b0;

        // Load a word at 0 and fetch it; hold the response for 5 cycles.
        ld_write(8'd0, 8'hB3);
        ld_write(8'd1, 8'h81);
        ld_write(8'd2, 8'h40);
        ld_write(8'd3, 8'h00);
        fetch(32'h0000_0000, 5, 1'b0);
        check("word0", bus.instr, 32'h0040_81B3);

        // Misaligned fetch.
        fetch(32'h0000_0002, 2, 1'b0);

        // Loader and fetch request in the same idle cycle: write first.
        @(negedge clk);
        bus.ld_req    = 1'b1;
        bus.ld_addr   = 8'd4;
        bus.ld_data   = 8'h23;
        bus.fetch_req = 1'b1;
        bus.fetch_pc  = 32'h0000_0104;
        #1;
        check("coll_ack",    {31'd0, bus.ld_ack}, 32'd1);
        check("coll_fready", {31'd0, bus.fetch_ready}, 32'd0);
        ref_mem[4] = 8'h23;
        fetch(32'h0000_0104, 0, 1'b0);

        // Upper PC bits ignored.
        ld_write(8'd5, 8'h28);
        ld_write(8'd6, 8'h10);
        ld_write(8'd7, 8'h00);
        fetch(32'h0000_0104, 1, 1'b0);
        check("word104", bus.instr, 32'h0010_2823);

        // Reset while the third byte address is being presented.
        @(negedge clk);
        bus.ld_req    = 1'b0;
        bus.fetch_req = 1'b1;
        bus.fetch_pc  = 32'h0000_0000;
        repeat (3) begin
            @(negedge clk);
            bus.fetch_req = 1'b0;
        end
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        fetch(32'h0000_0004, 0, 1'b0);

        // Loader request raised while a fetch is in flight.
        fetch(32'h0000_0000, 2, 1'b1);

        // Random mix of loader writes and fetches.
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                ld_write(8'($urandom_range(0, 15) - 4), 8'($urandom_range(0, 255)));
            end else begin
                pc = $urandom;
                pc[7:0] = 8'($urandom_range(0, 15) - 4);
                if ($urandom_range(0, 3) != 0) pc[1:0] = 2'b00;
                fetch(pc, $urandom_range(0, 3), ($urandom_range(0, 3) == 0));
            end
        end

        @(negedge clk);
        bus.ld_req = 1'b0;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
